// File: rtl/pll_rst_ctrl.sv
// PLL reset/lock supervisor: pulses PLL reset with bounded retries, then releases three domain
// resets in order once lock is stable. All outputs are registered; lock loss drops domains within 3 edges.
module pll_rst_ctrl #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int STABLE_CYC       = 1024,
   parameter int GAP_CYC          = 8,
   parameter int MAX_RETRY        = 4,
   parameter int CNT_W            = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       soft_rst,
   output logic       pll_rst,
   output logic [2:0] dom_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [2:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
   localparam logic [2:0]       RETRY_LAST  = 3'(MAX_RETRY - 1);

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             lock_m;
   logic             lock_s;

   assign state = st;

   // pll_lock is asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= PLL_RST;
         pll_rst   <= 1'b1;
         dom_rst_n <= 3'b000;
         ready     <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= 3'd0;
         cnt       <= '0;
         idx       <= 2'd0;
      end else if (soft_rst) begin
         st        <= PLL_RST;
         pll_rst   <= 1'b1;
         dom_rst_n <= 3'b000;
         ready     <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= 3'd0;
         cnt       <= '0;
         idx       <= 2'd0;
      end else begin
         case (st)
            PLL_RST: begin
               if (cnt == RST_LAST) begin
                  st      <= WAIT_LOCK;
                  pll_rst <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  st  <= STABLE;
                  cnt <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt     <= '0;
                  pll_rst <= 1'b1;
                  if (retry_cnt == RETRY_LAST) begin
                     st   <= FAIL;
                     fail <= 1'b1;
                  end else begin
                     st        <= PLL_RST;
                     retry_cnt <= retry_cnt + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STABLE: begin
               // any low sample restarts the stability window with a fresh timeout
               if (!lock_s) begin
                  st  <= WAIT_LOCK;
                  cnt <= '0;
               end else if (cnt == STABLE_LAST) begin
                  st  <= RELEASE;
                  cnt <= '0;
                  idx <= 2'd0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (!lock_s) begin
                  st        <= PLL_RST;
                  pll_rst   <= 1'b1;
                  dom_rst_n <= 3'b000;
                  ready     <= 1'b0;
                  cnt       <= '0;
               end else if (cnt == GAP_LAST) begin
                  // shifting in ones keeps release strictly ordered bit0 -> bit2
                  dom_rst_n <= {dom_rst_n[1:0], 1'b1};
                  idx       <= idx + 2'd1;
                  cnt       <= '0;
                  if (idx == 2'd2) begin
                     st        <= RUN;
                     ready     <= 1'b1;
                     retry_cnt <= 3'd0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  st        <= PLL_RST;
                  pll_rst   <= 1'b1;
                  dom_rst_n <= 3'b000;
                  ready     <= 1'b0;
                  cnt       <= '0;
               end
            end
            FAIL: begin
               pll_rst   <= 1'b1;
               fail      <= 1'b1;
               dom_rst_n <= 3'b000;
               ready     <= 1'b0;
            end
            default: begin
               st      <= PLL_RST;
               pll_rst <= 1'b1;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: directed scenarios plus randomized lock/soft_rst traffic,
// checked every cycle against a timeline model of the supervisor.
module tb_pll_rst_ctrl;

   localparam int RP = 4, TO = 100, SC = 16, GP = 4, MR = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, pll_lock = 1'b0, soft_rst = 1'b0;
   logic       pll_rst, ready, fail;
   logic [2:0] dom_rst_n, retry_cnt, state;

   logic       rst2_n = 1'b0, lock2 = 1'b0, soft2 = 1'b0;
   logic       pll_rst2, ready2, fail2;
   logic [2:0] dom2, retry2, state2;

   int n_tests = 0, n_fail = 0;

   // model: phase (encoded as the externally visible state code), cycles spent in phase, retries
   int   m_mode = 0, m_t = 0, m_retry = 0;
   logic l1 = 1'b0, l2 = 1'b0, lk = 1'b0;

   always #10 clk = ~clk;

   pll_rst_ctrl #(.RST_PULSE_CYC(RP), .LOCK_TIMEOUT_CYC(TO), .STABLE_CYC(SC),
                  .GAP_CYC(GP), .MAX_RETRY(MR), .CNT_W(20)) dut (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .soft_rst(soft_rst),
      .pll_rst(pll_rst), .dom_rst_n(dom_rst_n), .ready(ready), .fail(fail),
      .retry_cnt(retry_cnt), .state(state));

   pll_rst_ctrl dut_d (
      .clk(clk), .rst_n(rst2_n), .pll_lock(lock2), .soft_rst(soft2),
      .pll_rst(pll_rst2), .dom_rst_n(dom2), .ready(ready2), .fail(fail2),
      .retry_cnt(retry2), .state(state2));

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic go(input int mode);
      m_mode = mode;
      m_t    = 0;
   endtask

   task automatic model_step();
      lk = l2; l2 = l1; l1 = pll_lock;
      m_t++;
      if (soft_rst) begin
         go(0);
         m_retry = 0;
      end else begin
         case (m_mode)
            0: if (m_t == RP) go(1);
            1: if (lk) go(2);
               else if (m_t == TO) begin
                  if (m_retry == MR - 1) go(5);
                  else begin m_retry++; go(0); end
               end
            2: if (!lk) go(1); else if (m_t == SC) go(3);
            3: if (!lk) go(0); else if (m_t == 3 * GP) begin go(4); m_retry = 0; end
            4: if (!lk) go(0);
            default: ;
         endcase
      end
   endtask

   function automatic int exp_dom();
      if (m_mode == 3) return (1 << (m_t / GP)) - 1;
      if (m_mode == 4) return 7;
      return 0;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         go(0); m_retry = 0; l1 = 1'b0; l2 = 1'b0;
      end else begin
         model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (n_fail < 50) begin
         chk("m_state", int'(state), m_mode);
         chk("m_pll_rst", int'(pll_rst), int'(m_mode == 0 || m_mode == 5));
         chk("m_dom_rst_n", int'(dom_rst_n), exp_dom());
         chk("m_ready", int'(ready), int'(m_mode == 4));
         chk("m_fail", int'(fail), int'(m_mode == 5));
         chk("m_retry_cnt", int'(retry_cnt), m_retry);
      end
   end

   task automatic wait_state(input int s, input int budget, input string name);
      int n = 0;
      while (int'(state) != s && n < budget) begin
         tick();
         n++;
      end
      chk(name, int'(state), s);
   endtask

   initial begin
      int n, w, rises, t_pll, t_stab, t_rel, t_d0, t_d1, t_run;
      logic prev;
      repeat (3) tick();
      chk("rst_state", int'(state), 0);
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_dom", int'(dom_rst_n), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_retry", int'(retry_cnt), 0);

      // lock never asserts
      rst_n = 1'b1;
      n = 0; w = 0; rises = 0; prev = 1'b1;
      while (!fail && n < 400) begin
         tick(); n++;
         if (fail) break;
         if (state == 3'd1) w++;
         if (pll_rst && !prev) rises++;
         prev = pll_rst;
      end
      chk("t2_edges_to_fail", n, 208);
      chk("t2_wait_cycles", w, 200);
      chk("t2_retry_pulses", rises, 1);
      chk("t2_retry_in_fail", int'(retry_cnt), 1);
      chk("t2_pll_rst_held", int'(pll_rst), 1);

      // nominal bring-up, lock 10 cycles after reset release
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      t_pll = -1; t_stab = -1; t_rel = -1; t_d0 = -1; t_d1 = -1; t_run = -1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (i == 10) pll_lock = 1'b1;
         if (t_pll < 0 && !pll_rst) t_pll = i;
         if (t_stab < 0 && state == 3'd2) t_stab = i;
         if (t_rel < 0 && state == 3'd3) t_rel = i;
         if (t_d0 < 0 && dom_rst_n == 3'b001) t_d0 = i;
         if (t_d1 < 0 && dom_rst_n == 3'b011) t_d1 = i;
         if (ready) begin t_run = i; break; end
      end
      chk("t1_pll_rst_fall", t_pll, 4);
      chk("t1_stable_entry", t_stab, 13);
      chk("t1_release_entry", t_rel, 29);
      chk("t1_dom_001", t_d0, 33);
      chk("t1_dom_011", t_d1, 37);
      chk("t1_ready", t_run, 41);
      chk("t1_state_run", int'(state), 4);
      chk("t1_dom_111", int'(dom_rst_n), 7);

      // lock loss in RUN
      pll_lock = 1'b0;
      n = 0;
      while ((dom_rst_n != 3'b000 || ready) && n < 10) begin tick(); n++; end
      chk("t4_drop_within_3", int'(n >= 1 && n <= 3), 1);
      chk("t4_state_pll_rst", int'(state), 0);
      pll_lock = 1'b1;
      wait_state(2, 50, "t4_relock_stable");

      // lock loss 10 cycles into STABLE
      repeat (10) tick();
      chk("t3_still_stable", int'(state), 2);
      pll_lock = 1'b0;
      wait_state(1, 10, "t3_back_to_wait");
      chk("t3_retry_unchanged", int'(retry_cnt), 0);
      pll_lock = 1'b1;
      wait_state(2, 20, "t3_restable");
      n = 0;
      while (state == 3'd2 && n < 40) begin tick(); n++; end
      chk("t3_stable_len", n, 16);
      wait_state(4, 40, "t3_run_again");

      // FAIL, then soft reset recovery
      pll_lock = 1'b0;
      wait_state(5, 400, "t5_fail");
      pll_lock = 1'b1;
      repeat (5) tick();
      chk("t5_fail_sticky", int'(state), 5);
      soft_rst = 1'b1; tick(); soft_rst = 1'b0;
      chk("t5_soft_fail", int'(fail), 0);
      chk("t5_soft_retry", int'(retry_cnt), 0);
      chk("t5_soft_state", int'(state), 0);
      wait_state(4, 100, "t5_ready_after_soft");
      chk("t5_ready", int'(ready), 1);

      // soft_rst in the same cycle the FSM sees lock loss
      pll_lock = 1'b0; tick(); tick();
      soft_rst = 1'b1; tick(); soft_rst = 1'b0;
      chk("t5_coinc_state", int'(state), 0);
      chk("t5_coinc_retry", int'(retry_cnt), 0);
      chk("t5_coinc_dom", int'(dom_rst_n), 0);

      // randomized lock segments with rare soft resets
      for (int seg = 0; seg < 120; seg++) begin
         int  len;
         logic lv;
         lv = ($urandom_range(0, 9) < 7);
         len = lv ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 250));
         pll_lock = lv;
         for (int i = 0; i < len; i++) begin
            soft_rst = ($urandom_range(0, 299) == 0);
            tick();
         end
         soft_rst = 1'b0;
      end

      // default parameters: async reset mid-release
      rst2_n = 1'b1; lock2 = 1'b1;
      n = 0;
      while (dom2 != 3'b011 && n < 3000) begin tick(); n++; end
      chk("t6_mid_release", int'(dom2), 3);
      @(negedge clk); #3;
      rst2_n = 1'b0;
      #1;
      chk("t6_async_state", int'(state2), 0);
      chk("t6_async_pll_rst", int'(pll_rst2), 1);
      chk("t6_async_dom", int'(dom2), 0);
      chk("t6_async_ready", int'(ready2), 0);
      chk("t6_async_fail", int'(fail2), 0);
      chk("t6_async_retry", int'(retry2), 0);
      tick(); rst2_n = 1'b1;
      tick();
      chk("t6_restart_state", int'(state2), 0);
      n = 0;
      while (state2 != 3'd2 && n < 40) begin tick(); n++; end
      chk("t6_restart_stable", int'(state2), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_rst_ctrl.md
Name: pll_rst_ctrl

Overview:
Reset and lock supervisor for the PLL clock generator, running on the free-running PLL reference clock (50 MHz board clock).
- Drives the PLL RST input and watches its LOCK output.
- Retries lock with a bounded number of PLL reset pulses.
- Releases three per-output-clock domain resets in order once lock has been stable long enough.
- Sits between the board clock/reset pins and the PLL instance; domain logic re-synchronizes each dom_rst_n into its own clock.

Parameters:
RST_PULSE_CYC, 16, cycles pll_rst is held high per PLL reset attempt (>=1)
LOCK_TIMEOUT_CYC, 50000, cycles allowed in WAIT_LOCK before a retry (1 ms @ 50 MHz)
STABLE_CYC, 1024, cycles lock must stay continuously high before releasing domains
GAP_CYC, 8, cycles between successive domain reset releases (>=1)
MAX_RETRY, 4, PLL reset attempts allowed before FAIL (1..7)
CNT_W, 20, shared counter width; must hold max(all *_CYC)-1

Ports:
clk  in  1  free-running reference clock (same net as PLL clkin1)
rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL LOCK, asynchronous to clk
soft_rst  in  1  single-cycle request to restart the full sequence
pll_rst  out  1  to PLL RST, active high
dom_rst_n  out  3  domain resets, active low; bit0=clkout0, bit1=clkout1, bit2=clkout2
ready  out  1  all domains released, PLL locked
fail  out  1  retries exhausted
retry_cnt  out  3  failed lock attempts since last RUN/soft_rst
state  out  3  FSM state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN, 5 FAIL

Behaviour:
- Reset (rst_n=0, async): state=PLL_RST, pll_rst=1, dom_rst_n=3'b000, ready=0, fail=0, retry_cnt=0, cnt=0, idx=0. All outputs are registered.
- Lock synchronizer: pll_lock passes through a 2-FF sync to give lock_s. The FSM uses lock_s only.
- cnt clears on every state transition.
- PLL_RST: pll_rst=1. At cnt==RST_PULSE_CYC-1, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - If lock_s=1, go to STABLE.
  - Else at cnt==LOCK_TIMEOUT_CYC-1: if retry_cnt==MAX_RETRY-1, go to FAIL; otherwise increment retry_cnt and go to PLL_RST.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK. The timeout restarts and retry_cnt is unchanged.
  - At cnt==STABLE_CYC-1, go to RELEASE with idx=0.
- RELEASE: at cnt==GAP_CYC-1, set dom_rst_n[idx]=1, increment idx and clear cnt. When bit2 is set, go to RUN in the same edge and set ready=1.
- RUN: ready=1, retry_cnt cleared to 0, pll_rst=0.
- Lock loss in RELEASE or RUN (lock_s=0):
  - On the next edge: dom_rst_n=000, ready=0, go to PLL_RST.
  - retry_cnt is unchanged; it is already 0 in RUN.
  - Latency from pll_lock falling to dom_rst_n low is at most 3 clk edges.
- FAIL: pll_rst=1, fail=1, dom_rst_n=000, ready=0. Stays until soft_rst or rst_n.
- soft_rst=1 (any state, including FAIL), on the next edge:
  - state=PLL_RST, pll_rst=1, dom_rst_n=000, ready=0, fail=0, retry_cnt=0, cnt=0.
  - soft_rst has priority over lock loss and over all counter terminal conditions in the same cycle.
- Release invariants:
  - dom_rst_n bits only ever deassert in order bit0, then bit1, then bit2, exactly GAP_CYC cycles apart.
  - They always assert together.
- Glitch rule: pll_lock glitches shorter than 2 clk periods may be missed. Any lock_s low sample restarts STABLE.

Test Plan:
(Overrides for 1–5: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, STABLE_CYC=16, GAP_CYC=4, MAX_RETRY=2.)
1. Nominal: release rst_n, raise pll_lock 10 cycles later -> pll_rst high 4 cycles; state 1, then 2 after 2-cycle sync; 16 cycles later state 3; dom_rst_n goes 001/011/111 at 4-cycle spacing; ready=1, state=4, retry_cnt=0.
2. Lock never asserts -> pll_rst pulses twice (4 cycles each); WAIT_LOCK lasts 100 cycles each time; retry_cnt reaches 1; then state=5, fail=1, pll_rst=1 held.
3. Lock drops at cycle 10 of STABLE -> state returns to 1, no retry_cnt change; relock -> full 16-cycle STABLE count restarts.
4. Lock drops in RUN -> dom_rst_n=000 and ready=0 within 3 edges of the pll_lock fall; state=0; relock -> ordered release again.
5. In FAIL, pulse soft_rst -> next edge fail=0, retry_cnt=0, state=0; lock then succeeds -> ready=1. Also check soft_rst coinciding with lock loss in RUN -> PLL_RST with retry_cnt=0.
6. Defaults, rst_n asserted mid-RELEASE (dom_rst_n=011) -> all outputs return to reset values immediately (asynchronously); sequence restarts from PLL_RST.
